// File: rtl/digest_word_reader.sv
// digest_word_reader: snapshots a DIGEST_W digest on start and streams it as WORD_W words, MSW first.
// Optional byte reversal within each output word is enabled by defining DIGEST_READER_BYTE_SWAP_EN.
module digest_word_reader #(
  parameter int unsigned WORD_W   = 32,
  parameter int unsigned DIGEST_W = 256,
  localparam int unsigned NUM_WORDS = DIGEST_W / WORD_W,
  localparam int unsigned IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [DIGEST_W-1:0] digest,
  output logic                busy,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD_W-1:0]   out_data,
  output logic [IDX_W-1:0]    out_index,
  output logic                out_last,
  output logic                done
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam int unsigned      BYTES    = WORD_W / 8;

  logic [0:0]          state_q;
  logic [0:0]          state_d;
  logic [DIGEST_W-1:0] shadow_q;
  logic [DIGEST_W-1:0] shadow_d;
  logic [IDX_W-1:0]    idx_q;
  logic [IDX_W-1:0]    idx_d;

  logic                busy_d;
  logic                valid_d;
  logic [WORD_W-1:0]   data_d;
  logic [IDX_W-1:0]    index_d;
  logic                last_d;
  logic                done_d;

  // Word i of the snapshot, counted from the most-significant end.
  function automatic logic [WORD_W-1:0] select_word(input logic [DIGEST_W-1:0] s,
                                                    input logic [IDX_W-1:0]    i);
    logic [DIGEST_W-1:0] shifted;
    shifted = s << (WORD_W * 32'(i));
    return shifted[DIGEST_W-1 -: WORD_W];
  endfunction

  // Byte order seen by the consumer.
  function automatic logic [WORD_W-1:0] present(input logic [WORD_W-1:0] w);
`ifdef DIGEST_READER_BYTE_SWAP_EN
    logic [WORD_W-1:0] r;
    r = '0;
    for (int b = 0; b < int'(BYTES); b++) begin
      r[8*b +: 8] = w[WORD_W-8-8*b +: 8];
    end
    return r;
`else
    return w;
`endif
  endfunction

  // Next state, snapshot, index and the registered output values derived from them.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          shadow_d = digest;
          idx_d    = '0;
          state_d  = S_SEND;
        end
      end
      S_SEND: begin
        if (out_valid && out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d  = (state_d == S_SEND);
    valid_d = busy_d;
    index_d = busy_d ? idx_d : '0;
    last_d  = busy_d && (idx_d == LAST_IDX);
    data_d  = busy_d ? present(select_word(shadow_d, idx_d)) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shadow_q  <= '0;
      idx_q     <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      idx_q     <= idx_d;
      busy      <= busy_d;
      out_valid <= valid_d;
      out_data  <= data_d;
      out_index <= index_d;
      out_last  <= last_d;
      done      <= done_d;
    end
  end

endmodule
